// File: rtl/pc_gen.sv
// Fetch program-counter generator: trap/redirect/stall/return-prediction select with a
// circular return-address stack that overwrites its oldest entry when full.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d, pc_seq, ras_top;
  logic            pc_valid_q;
  logic            misalign_q, misalign_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] ptr_q, ptr_d, ras_waddr;
  logic            ras_we;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  assign pc_seq  = pc_q + XLEN'(4);
  assign ras_top = ras_q[ptr_q];

  always_comb begin
    pc_d       = pc_seq;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    misalign_d = 1'b0;
    ras_we     = 1'b0;
    ras_waddr  = ptr_q;
    if (trap) begin
      pc_d  = TRAP_VEC;
      cnt_d = '0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        pc_d       = TRAP_VEC;
        misalign_d = 1'b1;
        cnt_d      = '0;
      end else begin
        pc_d = redirect_pc;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ras_push && ras_pop) begin
      // Replace the top in place; an empty stack gains its first entry.
      if (cnt_q != '0) begin
        pc_d = ras_top;
      end else begin
        cnt_d = CntW'(1);
      end
      ras_we = 1'b1;
    end else if (ras_pop) begin
      if (cnt_q != '0) begin
        pc_d  = ras_top;
        cnt_d = cnt_q - CntW'(1);
        ptr_d = ptr_q - PtrW'(1);
      end
    end else if (ras_push) begin
      // Pointer wraps onto the oldest slot when the stack is already full.
      ptr_d     = ptr_q + PtrW'(1);
      ras_we    = 1'b1;
      ras_waddr = ptr_q + PtrW'(1);
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // Entry storage is never reset; contents are only read when the count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && ras_we) begin
      ras_q[ras_waddr] <= pc_seq;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign misalign_err = misalign_q;
  assign ras_empty    = (cnt_q == '0);
  assign ras_full     = (cnt_q == CntMax);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expected pc and flag values.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] pc;
  logic        pc_valid;
  logic        misalign_err;
  logic        ras_empty;
  logic        ras_full;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pc_gen #(
    .XLEN     (32),
    .RESET_VEC(32'h0000_0000),
    .TRAP_VEC (32'h0000_0100),
    .RAS_DEPTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap          (trap),
    .ras_push      (ras_push),
    .ras_pop       (ras_pop),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .misalign_err  (misalign_err),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap           = 1'b0;
    ras_push       = 1'b0;
    ras_pop        = 1'b0;
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", pc_valid, 0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_misalign", misalign_err, 0);

    // Reset release and sequential stepping
    rst = 1'b0;
    step();
    check("seq_pc4", pc, 32'h4);
    check("seq_valid", pc_valid, 1);
    step();
    check("seq_pc8", pc, 32'h8);
    step();
    check("seq_pcc", pc, 32'hC);
    step();
    check("seq_pc10", pc, 32'h10);

    // Stall for three edges, then redirect overrides stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", pc, 32'h10);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    check("redir_over_stall", pc, 32'h200);

    // Misaligned redirect
    stall       = 1'b0;
    redirect_pc = 32'h202;
    step();
    check("mis_pc", pc, 32'h100);
    check("mis_err", misalign_err, 1);
    check("mis_empty", ras_empty, 1);
    redirect_valid = 1'b0;
    step();
    check("mis_pulse_end", misalign_err, 0);
    check("mis_seq", pc, 32'h104);

    // Five pushes at 0x0..0x40 into a four-entry stack
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("push_at", pc, 32'(i * 16));
      ras_push = 1'b1;
      step();
      ras_push = 1'b0;
      check("push_full", ras_full, (i >= 3) ? 32'h1 : 32'h0);
      for (int j = 0; j < 3; j++) step();
    end
    check("push_end_pc", pc, 32'h50);
    ras_pop = 1'b1;
    step();
    check("pop1", pc, 32'h44);
    check("pop1_full", ras_full, 0);
    step();
    check("pop2", pc, 32'h34);
    step();
    check("pop3", pc, 32'h24);
    step();
    check("pop4", pc, 32'h14);
    check("pop4_empty", ras_empty, 1);
    step();
    check("pop5_empty_seq", pc, 32'h18);
    check("pop5_still_empty", ras_empty, 1);
    ras_pop = 1'b0;

    // Simultaneous push+pop at 0x50 with top 0x14
    do_reset();
    for (int i = 0; i < 4; i++) step();
    ras_push = 1'b1;
    step();
    ras_push = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("pp_start", pc, 32'h50);
    ras_push = 1'b1;
    ras_pop  = 1'b1;
    step();
    check("pp_pc", pc, 32'h14);
    check("pp_not_empty", ras_empty, 0);
    ras_push = 1'b0;
    step();
    check("pp_pop_ret", pc, 32'h54);
    check("pp_empty", ras_empty, 1);
    ras_pop = 1'b0;

    // Trap with redirect while stack is non-empty
    ras_push = 1'b1;
    step();
    ras_push = 1'b0;
    check("tr_nonempty", ras_empty, 0);
    trap           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    check("tr_pc", pc, 32'h100);
    check("tr_empty", ras_empty, 1);
    check("tr_no_misalign", misalign_err, 0);
    trap           = 1'b0;
    redirect_valid = 1'b0;

    // Wrap of the sequential step
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    check("wrap_zero", pc, 32'h0);
    check("wrap_no_err", misalign_err, 0);

    // Reset mid-stall with a push pending
    stall    = 1'b1;
    step();
    check("stall2_hold", pc, 32'h0);
    ras_push = 1'b1;
    rst      = 1'b1;
    step();
    check("rst_mid_pc", pc, 32'h0);
    check("rst_mid_valid", pc_valid, 0);
    check("rst_mid_empty", ras_empty, 1);
    rst      = 1'b0;
    stall    = 1'b0;
    ras_push = 1'b0;
    step();
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_valid", pc_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters (name, default, meaning):
- XLEN, 32, address width.
- RESET_VEC, 32'h0000_0000, pc value loaded by reset.
- TRAP_VEC, 32'h0000_0100, pc value loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, return-address-stack entries, power of two, minimum 2.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on posedge.
- rst, in, 1, synchronous, active-high reset.
- stall, in, 1, hold pc.
- redirect_valid, in, 1, branch or jump resolved taken.
- redirect_pc, in, XLEN, redirect target.
- trap, in, 1, exception request.
- ras_push, in, 1, current pc is a call.
- ras_pop, in, 1, current pc is a return.
- pc, out, XLEN, current fetch address (registered).
- pc_valid, out, 1, pc is a legal fetch address.
- misalign_err, out, 1, one-cycle pulse on misaligned redirect.
- ras_empty, out, 1, stack holds 0 entries.
- ras_full, out, 1, stack holds RAS_DEPTH entries.

REQ-003 All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.

Function
REQ-004 Next-pc priority, highest first: trap, then redirect_valid, then stall, then ras_pop, then sequential.
REQ-005 trap=1: pc <= TRAP_VEC and RAS count <= 0; all other inputs are ignored that cycle.
REQ-006 redirect_valid=1 and redirect_pc[1:0]==0: pc <= redirect_pc; stall is ignored; RAS is unchanged.
REQ-007 redirect_valid=1 and redirect_pc[1:0]!=0: pc <= TRAP_VEC, misalign_err=1 in the next cycle only, RAS count <= 0.
REQ-008 stall=1 with no trap or redirect: pc holds; ras_push and ras_pop are ignored.
REQ-009 Sequential step: pc <= pc + 4, modulo 2^XLEN (all-ones-minus-3 wraps to 0, no flag).
REQ-010 ras_pop with RAS not empty: pc <= top entry; count decrements.
REQ-011 ras_pop with RAS empty: pc <= pc + 4; count stays 0; no error.
REQ-012 ras_push: writes pc + 4 (current pc) to the top; count increments.
REQ-013 ras_push with RAS full: the entry is written circularly, overwriting the oldest; count saturates at RAS_DEPTH.
REQ-014 ras_push and ras_pop in the same cycle: pc <= old top (or pc + 4 if empty); top is replaced by pc + 4; count is unchanged (becomes 1 if it was 0).
REQ-015 ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are registered-state decodes.
REQ-016 pc_valid = 0 while rst=1; 1 from the first clock edge after rst deasserts and thereafter.
REQ-017 misalign_err defaults to 0 and is 1 only in the cycle following a misaligned redirect.

Reset
REQ-018 rst=1 at a clock edge sets: pc <= RESET_VEC, pc_valid <= 0, misalign_err <= 0, RAS count <= 0 (ras_empty=1, ras_full=0).
REQ-019 rst has priority over trap, redirect_valid, stall and RAS operations, including when asserted mid-stall or on a full stack.
REQ-020 RAS entry storage needs no reset; entry contents are unobservable when count==0.

Verification
REQ-021 Reset release, no stimulus: pc = 0x0, then 0x4, 0x8, 0xC on successive cycles; pc_valid rises 1 cycle after rst falls.
REQ-022 At pc=0x10, stall for 3 cycles, then redirect_pc=0x200 asserted together with stall: pc = 0x10 for 3 cycles, then 0x200.
REQ-023 redirect_pc=0x202: pc = 0x100; misalign_err=1 for exactly 1 cycle; ras_empty=1.
REQ-024 RAS_DEPTH=4; push at pc=0x0, 0x10, 0x20, 0x30, 0x40 (ras_full after the 4th push); then 5 pops yield 0x44, 0x34, 0x24, 0x14, and the 5th pop (empty) gives sequential pc + 4.
REQ-025 Simultaneous push+pop at pc=0x50 with top=0x14: next pc = 0x14; the following pop returns 0x54.
REQ-026 trap and redirect_valid together while the stack is non-empty: pc = 0x100, ras_empty=1; rst asserted mid-sequence: pc = 0x0, pc_valid=0.
